// File: rtl/pattern_tx_moore.sv
// pattern_tx_moore: serial pattern transmitter (Moore FSM, registered outputs).
// Captures a PAT_W-bit pattern and a repeat count on start. The pattern is
// shifted out MSB-first with a valid qualifier, repeat_n times (0 counts as
// one copy), with GAP idle cycles between copies. done pulses once at the end.
// Optional feature macro: PATTERN_TX_PARITY_EN appends an even-parity bit to
// every copy.
module pattern_tx_moore #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [CNT_W-1:0] i_repeat_n,
    output logic             o_dout,
    output logic             o_dout_valid,
    output logic             o_busy,
    output logic             o_done
);

`ifdef PATTERN_TX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    // Parity rides as an extra LSB of the shift register, so it leaves the
    // line right after the last pattern bit with no extra control logic.
    localparam int unsigned SH_W     = PAT_W + PAR_W;
    localparam int unsigned BIT_W    = $clog2(SH_W);
    localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SH_W-1:0]    r_shreg;
    logic [SH_W-1:0]    w_shreg_nxt;
    logic [SH_W-1:0]    r_copy;
    logic [SH_W-1:0]    w_copy_nxt;
    logic [BIT_W-1:0]   r_bitcnt;
    logic [BIT_W-1:0]   w_bitcnt_nxt;
    logic [CNT_W-1:0]   r_copies;
    logic [CNT_W-1:0]   w_copies_nxt;
    logic [GAP_W-1:0]   r_gapcnt;
    logic [GAP_W-1:0]   w_gapcnt_nxt;
    logic               r_dout;
    logic               r_dout_valid;
    logic               r_busy;
    logic               r_done;
    logic               w_dout_nxt;
    logic               w_dout_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [SH_W-1:0]    w_capture;

    // Value loaded into the shift register for each copy.
`ifdef PATTERN_TX_PARITY_EN
    assign w_capture = {i_pattern, ^i_pattern};
`else
    assign w_capture = i_pattern;
`endif

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_copy       <= '0;
            r_bitcnt     <= '0;
            r_copies     <= '0;
            r_gapcnt     <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_copy       <= w_copy_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_copies     <= w_copies_nxt;
            r_gapcnt     <= w_gapcnt_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next-state and datapath updates; outputs are decoded from the next state.
    always_comb begin
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_copy_nxt       = r_copy;
        w_bitcnt_nxt     = r_bitcnt;
        w_copies_nxt     = r_copies;
        w_gapcnt_nxt     = r_gapcnt;
        w_dout_nxt       = 1'b0;
        w_dout_valid_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_copy_nxt   = w_capture;
                    w_shreg_nxt  = w_capture;
                    w_bitcnt_nxt = BIT_W'(SH_W - 1);
                    w_copies_nxt = (i_repeat_n == '0) ? '0 : i_repeat_n - CNT_W'(1);
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bitcnt != '0) begin
                    w_shreg_nxt  = r_shreg << 1;
                    w_bitcnt_nxt = r_bitcnt - BIT_W'(1);
                end else if (r_copies != '0) begin
                    if (GAP != 0) begin
                        w_gapcnt_nxt = GAP_W'(GAP_LOAD);
                        w_state_nxt  = ST_GAP;
                    end else begin
                        w_shreg_nxt  = r_copy;
                        w_bitcnt_nxt = BIT_W'(SH_W - 1);
                        w_copies_nxt = r_copies - CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_GAP: begin
                if (r_gapcnt == '0) begin
                    w_shreg_nxt  = r_copy;
                    w_bitcnt_nxt = BIT_W'(SH_W - 1);
                    w_copies_nxt = r_copies - CNT_W'(1);
                    w_state_nxt  = ST_SHIFT;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - GAP_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        case (w_state_nxt)
            ST_SHIFT: begin
                w_dout_nxt       = w_shreg_nxt[SH_W-1];
                w_dout_valid_nxt = 1'b1;
                w_busy_nxt       = 1'b1;
            end
            ST_GAP: begin
                w_busy_nxt = 1'b1;
            end
            ST_DONE: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_pattern_tx_moore.sv
// Testbench for pattern_tx_moore: a GAP=1 instance and a GAP=0 instance.
// Observed outputs are packed as {dout, dout_valid, busy, done}.
module tb_pattern_tx_moore;

    logic       clk;
    logic       rst;
    logic       start_g1;
    logic       start_g0;
    logic [3:0] pattern;
    logic [3:0] repeat_n;
    logic       dout_g1, valid_g1, busy_g1, done_g1;
    logic       dout_g0, valid_g0, busy_g0, done_g0;

    int checks   = 0;
    int failures = 0;

    pattern_tx_moore #(.PAT_W(4), .CNT_W(4), .GAP(1)) u_dut_g1 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start_g1),
        .i_pattern   (pattern),
        .i_repeat_n  (repeat_n),
        .o_dout      (dout_g1),
        .o_dout_valid(valid_g1),
        .o_busy      (busy_g1),
        .o_done      (done_g1)
    );

    pattern_tx_moore #(.PAT_W(4), .CNT_W(4), .GAP(0)) u_dut_g0 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start_g0),
        .i_pattern   (pattern),
        .i_repeat_n  (repeat_n),
        .o_dout      (dout_g0),
        .o_dout_valid(valid_g0),
        .o_busy      (busy_g0),
        .o_done      (done_g0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PATTERN_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] pat;
        logic [3:0] rep;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [3:0] obs(input int sel);
        if (sel == 0) return {dout_g1, valid_g1, busy_g1, done_g1};
        return {dout_g0, valid_g0, busy_g0, done_g0};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {dout,valid,busy,done}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_g1 = v;
        else          start_g0 = v;
    endtask

    // Runs one job on the selected instance (0: GAP=1, 1: GAP=0) and checks
    // every cycle against a reference stream. With disturb set, the pattern
    // port changes and start stays high from cycle 2 through the DONE edge.
    task automatic run_job(input string name, input int sel, input logic [3:0] pat,
                           input logic [3:0] rep, input bit disturb);
        logic [3:0] q[$];
        int copies;
        int gap;
        copies = (rep == 4'd0) ? 1 : int'(rep);
        gap    = (sel == 0) ? 1 : 0;
        for (int c = 0; c < copies; c++) begin
            for (int b = 3; b >= 0; b--) q.push_back({pat[b], 3'b110});
            if (PAR) q.push_back({^pat, 3'b110});
            if (c < copies - 1)
                for (int g = 0; g < gap; g++) q.push_back(4'b0010);
        end
        q.push_back(4'b0011);
        q.push_back(4'b0000);

        pattern  = pat;
        repeat_n = rep;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("%s_cyc%0d", name, k + 1), obs(sel), q[k]);
            if (disturb && k == 1) begin
                pattern = 4'b1111;
                set_start(sel, 1'b1);
            end
        end
        set_start(sel, 1'b0);
        @(posedge clk); #1;
        check($sformatf("%s_idle_after", name), obs(sel), 4'b0000);
    endtask

    initial begin
        rst      = 1'b0;
        start_g1 = 1'b0;
        start_g0 = 1'b0;
        pattern  = 4'b0000;
        repeat_n = 4'd0;

        // Reset, then a single 1011 job on the GAP=1 instance.
        tbl[0] = '{rst:1'b1, start:1'b0, pat:4'b0000, rep:4'd0, exp:4'b0000};
        tbl[1] = '{rst:1'b0, start:1'b1, pat:4'b1011, rep:4'd1, exp:4'b1110};
        tbl[2] = '{rst:1'b0, start:1'b0, pat:4'b0000, rep:4'd0, exp:4'b0110};
        tbl[3] = '{rst:1'b0, start:1'b0, pat:4'b0000, rep:4'd0, exp:4'b1110};
        tbl[4] = '{rst:1'b0, start:1'b0, pat:4'b0000, rep:4'd0, exp:4'b1110};
        tbl[5] = '{rst:1'b0, start:1'b0, pat:4'b0000, rep:4'd0,
                   exp:(PAR ? 4'b1110 : 4'b0011)};
        tbl[6] = '{rst:1'b0, start:1'b0, pat:4'b0000, rep:4'd0,
                   exp:(PAR ? 4'b0011 : 4'b0000)};
        tbl[7] = '{rst:1'b0, start:1'b0, pat:4'b0000, rep:4'd0, exp:4'b0000};

        for (int i = 0; i < 8; i++) begin
            rst      = tbl[i].rst;
            start_g1 = tbl[i].start;
            pattern  = tbl[i].pat;
            repeat_n = tbl[i].rep;
            @(posedge clk); #1;
            check($sformatf("table_%0d", i), obs(0), tbl[i].exp);
            if (i == 0) check("reset_gap0", obs(1), 4'b0000);
        end
        start_g1 = 1'b0;

        run_job("rep3_gap1", 0, 4'b1011, 4'd3, 1'b0);
        run_job("rep2_gap0", 1, 4'b1100, 4'd2, 1'b0);
        run_job("rep0_disturb", 0, 4'b0110, 4'd0, 1'b1);

        // Reset during cycle 2 of a job: line goes quiet, no done pulse.
        pattern  = 4'b1011;
        repeat_n = 4'd1;
        start_g1 = 1'b1;
        @(posedge clk); #1;
        start_g1 = 1'b0;
        check("rst_job_cyc1", obs(0), 4'b1110);
        @(posedge clk); #1;
        check("rst_job_cyc2", obs(0), 4'b0110);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_job_cyc3", obs(0), 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_job_quiet%0d", i), obs(0), 4'b0000);
        end
        run_job("after_reset", 0, 4'b1011, 4'd1, 1'b0);

        run_job("pat1001", 0, 4'b1001, 4'd1, 1'b0);
        run_job("rep15_gap0", 1, 4'b1010, 4'd15, 1'b0);
        run_job("rep2_gap0_dist", 1, 4'b0101, 4'd2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_tx_moore.md
Name: pattern_tx_moore

Overview:
- Serial pattern transmitter; the sending end of the team's serial bit-pattern detectors.
- Captures a PAT_W-bit pattern and a repeat count on a start strobe.
- Shifts the pattern out MSB-first on a 1-bit line with a qualifying valid, repeating it N times with a fixed idle gap between copies.
- Moore FSM: all outputs are registered and depend on state only.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of repeat count
GAP, 1, idle cycles between repeated copies (0 = back-to-back)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request to begin transmission; sampled only in IDLE
pattern  in  PAT_W  bit pattern, captured on accepted start
repeat_n  in  CNT_W  number of copies to send, captured on accepted start; 0 treated as 1
dout  out  1  serial data, MSB of pattern first
dout_valid  out  1  high when dout carries a pattern (or parity) bit
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse after the final bit

Behaviour:
- Reset: reset=1 at a clk edge forces state IDLE and all outputs to 0 from that edge. Applies in any state; mid-shift data is discarded with no done pulse. Internal shift register and counters are cleared.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: dout=0, dout_valid=0, busy=0, done=0.
  - start=1 at edge E captures pattern into the shift register, loads bit counter=PAT_W-1, and loads copies_left=max(repeat_n,1)-1. Next state is SHIFT.
- SHIFT: dout=shreg[MSB], dout_valid=1, busy=1.
  - The first bit appears in the cycle after edge E (latency 1).
  - Each edge shifts left by one and decrements the bit counter.
  - When the last bit of a copy is on the line:
    - copies_left>0 and GAP>0: go to GAP.
    - copies_left>0 and GAP=0: reload pattern and stay in SHIFT with no bubble.
    - copies_left=0: go to DONE.
  - The captured pattern is reloaded for each copy; the pattern port is ignored after capture.
- GAP: dout=0, dout_valid=0, busy=1.
  - Held for exactly GAP cycles.
  - Then reload shreg from the captured copy, decrement copies_left, and return to SHIFT.
- DONE: done=1, busy=1, dout=0, dout_valid=0, for exactly one cycle; then IDLE.
- start is ignored in SHIFT, GAP and DONE. start held high continuously re-triggers only from IDLE, so there is one IDLE cycle between jobs.
- Total busy cycles per job: copies*PAT_W + (copies-1)*GAP + 1.
- Counters never wrap: the bit counter saturates at 0 on the state exit, and copies_left is decremented only while >0.

Optional Feature:
- Macro: PATTERN_TX_PARITY_EN.
- Defined: after the last pattern bit of each copy, one extra SHIFT-qualified cycle drives the even-parity bit (XOR of the PAT_W captured bits) with dout_valid=1, before GAP/DONE. Busy length becomes copies*(PAT_W+1) + (copies-1)*GAP + 1.
- Not defined: no parity cycle; behaviour exactly as above.

Test Plan:
- PAT_W=4, GAP=1, pattern=4'b1011, repeat_n=1, start at edge 0 -> dout/valid=1,0,1,1 in cycles 1-4; done=1 in cycle 5 only; busy high cycles 1-5; IDLE in cycle 6.
- pattern=1011, repeat_n=3, GAP=1 -> valid stream 1011, one invalid cycle with dout=0, 1011, gap, 1011; done in cycle 15; busy for 15 cycles.
- GAP=0, pattern=1100, repeat_n=2 -> dout=1,1,0,0,1,1,0,0 with valid continuously high for 8 cycles; done in cycle 9.
- repeat_n=0, pattern=0110 -> exactly one copy 0,1,1,0 then done. Pattern port changed to 1111 mid-job and start pulsed while busy -> output unaffected, no second job.
- reset asserted in cycle 2 of a 1011 job -> from the next cycle dout=0, dout_valid=0, busy=0, done never pulses. A new start afterwards transmits cleanly.
- PATTERN_TX_PARITY_EN defined, pattern=1011, repeat_n=1 -> 1,0,1,1 then parity bit 1 with valid=1 in cycle 5; done in cycle 6. Pattern 1001 -> parity bit 0.
